// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types and default constants for the blink rate controller
package blink_pkg;

    localparam int MODE_W = 2;

    localparam int DEBOUNCE_CYC_DEF = 500000;
    localparam int HALF_P0_DEF      = 25000000;
    localparam int HALF_P1_DEF      = 12500000;
    localparam int HALF_P2_DEF      = 6250000;
    localparam int HALF_P3_DEF      = 5000;
    localparam int CNT_W_DEF        = 26;
    localparam int DEB_W_DEF        = 20;

    typedef logic [MODE_W-1:0] mode_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

endpackage

// File: rtl/blink_rate_ctrl_if.sv
// rtl/blink_rate_ctrl_if.sv - button input and rate/tick outputs of the blink rate controller
interface blink_rate_ctrl_if;
    import blink_pkg::*;

    logic  key_n;
    logic  press;
    mode_t mode;
    logic  tick;

    modport master (
        output key_n,
        input  press,
        input  mode,
        input  tick
    );

    modport slave (
        input  key_n,
        output press,
        output mode,
        output tick
    );
endinterface

// File: rtl/blink_rate_ctrl_key_debounce.sv
// rtl/blink_rate_ctrl_key_debounce.sv - button synchronizer and debounce FSM producing press pulses
module key_debounce
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int DEB_W        = DEB_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press,
    output logic press_set
);

    localparam logic [DEB_W-1:0] DCNT_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             key_s;
    db_state_t        state_q;
    db_state_t        state_d;
    logic [DEB_W-1:0] dcnt_q;
    logic [DEB_W-1:0] dcnt_d;
    logic             press_q;
    logic             press_d;

    // Flops reset to 1 so a button held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            key_s <= 1'b1;
        end else begin
            sync1 <= key_n;
            key_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_d = REL_WAIT;
                    dcnt_d  = '0;
                end
            end
            REL_WAIT: begin
                // A bounce during release returns to HELD without producing a second press.
                if (!key_s) begin
                    state_d = HELD;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    assign press     = press_q;
    assign press_set = press_d;

endmodule

// File: rtl/blink_rate_ctrl.sv
// rtl/blink_rate_ctrl.sv - debounced rate-mode stepping and per-mode tick generator
module blink_rate_ctrl
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int HALF_P0      = HALF_P0_DEF,
    parameter int HALF_P1      = HALF_P1_DEF,
    parameter int HALF_P2      = HALF_P2_DEF,
    parameter int HALF_P3      = HALF_P3_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEB_W        = DEB_W_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    blink_rate_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] P0_LAST = CNT_W'(HALF_P0 - 1);
    localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(HALF_P1 - 1);
    localparam logic [CNT_W-1:0] P2_LAST = CNT_W'(HALF_P2 - 1);
    localparam logic [CNT_W-1:0] P3_LAST = CNT_W'(HALF_P3 - 1);

    logic             press;
    logic             press_set;
    mode_t            mode_q;
    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] period_last;
    logic             tick_q;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .DEB_W        (DEB_W)
    ) u_debounce (
        .clk       (CLOCK_50),
        .reset     (reset),
        .key_n     (bus.key_n),
        .press     (press),
        .press_set (press_set)
    );

    always_comb begin
        period_last = P0_LAST;
        case (mode_q)
            2'd0:    period_last = P0_LAST;
            2'd1:    period_last = P1_LAST;
            2'd2:    period_last = P2_LAST;
            2'd3:    period_last = P3_LAST;
            default: period_last = P0_LAST;
        endcase
    end

    // press_set is the debounce FSM's accept decision, so mode steps on the same edge press rises.
    // A mode change restarts the phase and suppresses the tick for that edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode_q <= '0;
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else if (press_set) begin
            mode_q <= mode_t'(mode_q + 1'b1);
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else if (pcnt_q == period_last) begin
            pcnt_q <= '0;
            tick_q <= 1'b1;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign bus.press = press;
    assign bus.mode  = mode_q;
    assign bus.tick  = tick_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// tb/tb_blink_rate_ctrl.sv - directed self-checking bench for blink_rate_ctrl
module tb_blink_rate_ctrl;

    typedef struct {
        int low1;
        int high1;
        int low2;
        int rel;
        int exp_off;
        int exp_presses;
        int exp_mode;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   press_cnt;
    int   last_press;
    int   tick_log[$];
    int   periods[4];
    vec_t vecs[6];

    blink_rate_ctrl_if bus ();

    blink_rate_ctrl #(
        .DEBOUNCE_CYC (8),
        .HALF_P0      (10),
        .HALF_P1      (6),
        .HALF_P2      (4),
        .HALF_P3      (2),
        .CNT_W        (8),
        .DEB_W        (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.press === 1'b1) begin
                press_cnt++;
                last_press = cyc;
            end
            if (bus.tick === 1'b1) tick_log.push_back(cyc);
        end
    endtask

    // Ticks at or after base must land exactly on base+k*per, k>=1, up to the current cycle.
    task automatic check_ticks(input string name, input int base, input int per);
        int got;
        int bad;
        got = 0;
        bad = 0;
        foreach (tick_log[k]) begin
            if (tick_log[k] >= base) begin
                got++;
                if (tick_log[k] == base || ((tick_log[k] - base) % per) != 0) bad++;
            end
        end
        check({name, " tick_count"}, got, (cyc - base) / per);
        check({name, " tick_misplaced"}, bad, 0);
    endtask

    task automatic run_row(input int idx);
        vec_t v;
        int   e0;
        int   p;
        v = vecs[idx];
        press_cnt  = 0;
        last_press = -1;
        tick_log.delete();
        bus.key_n = 1'b0;
        e0 = cyc + 1;
        step(v.low1);
        bus.key_n = 1'b1;
        step(v.high1);
        bus.key_n = 1'b0;
        step(v.low2);
        bus.key_n = 1'b1;
        step(v.rel);
        p = e0 + v.exp_off;
        check($sformatf("row%0d press_count", idx), press_cnt, v.exp_presses);
        check($sformatf("row%0d press_edge", idx), last_press, p);
        check($sformatf("row%0d mode", idx), int'(bus.mode), v.exp_mode);
        check_ticks($sformatf("row%0d", idx), p, periods[v.exp_mode]);
    endtask

    initial begin
        int rel;
        int e0;
        n_cmp      = 0;
        n_fail     = 0;
        cyc        = 0;
        press_cnt  = 0;
        last_press = -1;
        periods    = '{10, 6, 4, 2};
        //             low1 high1 low2 rel off presses mode
        vecs[0] = '{20, 0, 0,  20, 10, 1, 1};  // clean press
        vecs[1] = '{5,  1, 20, 20, 16, 1, 2};  // bounce, timed from final low
        vecs[2] = '{12, 0, 0,  12, 10, 1, 3};
        vecs[3] = '{12, 0, 0,  12, 10, 1, 0};  // wrap 3->0
        vecs[4] = '{40, 0, 0,  20, 10, 1, 1};  // long hold, single press
        vecs[5] = '{20, 4, 2,  20, 10, 1, 2};  // release glitch in REL_WAIT

        // Reset held while the key toggles
        reset     = 1'b1;
        bus.key_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
            check($sformatf("rst%0d press", i), int'(bus.press), 0);
            check($sformatf("rst%0d mode", i), int'(bus.mode), 0);
            check($sformatf("rst%0d tick", i), int'(bus.tick), 0);
        end
        reset     = 1'b0;
        bus.key_n = 1'b1;
        rel       = cyc;
        press_cnt = 0;
        tick_log.delete();
        step(35);
        check("post_rst press_count", press_cnt, 0);
        check("post_rst mode", int'(bus.mode), 0);
        check_ticks("post_rst", rel, 10);
        check("post_rst first_tick", (tick_log.size() > 0) ? tick_log[0] : -1, rel + 10);

        for (int i = 0; i < 6; i++) run_row(i);

        // One-cycle reset in PRESS_WAIT with dcnt at 5
        bus.key_n = 1'b0;
        e0 = cyc + 1;
        press_cnt = 0;
        step(8);
        reset     = 1'b1;
        bus.key_n = 1'b1;
        step(1);
        check("midrst press", int'(bus.press), 0);
        check("midrst mode", int'(bus.mode), 0);
        check("midrst tick", int'(bus.tick), 0);
        reset = 1'b0;
        rel   = cyc;
        tick_log.delete();
        step(25);
        check("midrst press_count", press_cnt, 0);
        check("midrst mode_after", int'(bus.mode), 0);
        check_ticks("midrst", rel, 10);
        check("midrst first_tick", (tick_log.size() > 0) ? tick_log[0] : -1, rel + 10);
        check("midrst e0_window", e0 + 8, rel);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
